// File: rtl/latch_wr_pkg.sv
// Shared types and constants for the latch-based register file write sequencer.
package latch_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W  = 4;
  localparam int GN_MAX = 64;

  // All gates high (latches opaque) for an array of nwords latches.
  function automatic logic [GN_MAX-1:0] gn_all_closed(input int nwords);
    logic [GN_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < GN_MAX; i++) begin
      if (i < nwords) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/latch_gn_decode.sv
// Registered active-low one-hot gate decoder; flops reset to all-closed so
// every latch is opaque the moment reset asserts.
module latch_gn_decode
  import latch_wr_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int AW     = 2
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              en_i,
  input  logic [AW-1:0]     addr_i,
  output logic [NWORDS-1:0] gn_o
);

  localparam logic [NWORDS-1:0] GN_ALL_CLOSED = NWORDS'(gn_all_closed(NWORDS));

  logic [NWORDS-1:0] gn_d;
  logic [NWORDS-1:0] gn_q;

  // Addresses beyond the last word match no bit, so they leave all gates high.
  always_comb begin
    gn_d = GN_ALL_CLOSED;
    for (int i = 0; i < NWORDS; i++) begin
      if (en_i && (32'(addr_i) == i)) gn_d[i] = 1'b0;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) gn_q <= GN_ALL_CLOSED;
    else     gn_q <= gn_d;
  end

  assign gn_o = gn_q;

endmodule

// File: rtl/latch_wr_ctrl.sv
// Write sequencer for a latch register file: SETUP -> OPEN -> HOLD per write.
// Define LATCH_WR_PARITY_EN to append an even-parity bit to lat_d.
module latch_wr_ctrl
  import latch_wr_pkg::*;
#(
  parameter int DW          = 8,
  parameter int NWORDS      = 4,
  parameter int OPEN_CYCLES = 1,
  localparam int AW         = $clog2(NWORDS),
`ifdef LATCH_WR_PARITY_EN
  localparam int LW         = DW + 1
`else
  localparam int LW         = DW
`endif
) (
  input  logic              CK,
  input  logic              RN,
  // Request handshake: a transfer happens on a rising CK edge where
  // req_valid && req_ready; the requester holds addr/data stable until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_data,
  output logic [LW-1:0]     lat_d,
  output logic [NWORDS-1:0] lat_gn,
  output logic              busy,
  output logic              wr_done,
  output logic              wr_err,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LW-1:0]     lat_d_q, lat_d_d;
  logic              req_ready_q;
  logic              busy_q;
  logic              wr_done_q;
  logic              wr_err_q;
  logic              accept;
  logic              addr_ok;

  assign accept  = req_valid && req_ready_q;
  assign addr_ok = 32'(addr_q) < NWORDS;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lat_d_d = lat_d_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          addr_d  = req_addr;
`ifdef LATCH_WR_PARITY_EN
          lat_d_d = {^req_data, req_data};
`else
          lat_d_d = req_data;
`endif
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CNT_W'(OPEN_CYCLES - 1);
      end
      OPEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe and never depend combinationally on inputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      lat_d_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      lat_d_q     <= lat_d_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      wr_done_q   <= (state_d == HOLD) && addr_ok;
      wr_err_q    <= (state_d == HOLD) && !addr_ok;
    end
  end

  latch_gn_decode #(
    .NWORDS (NWORDS),
    .AW     (AW)
  ) u_gn_decode (
    .CK     (CK),
    .RN     (RN),
    .en_i   (state_d == OPEN),
    .addr_i (addr_q),
    .gn_o   (lat_gn)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign wr_done   = wr_done_q;
  assign wr_err    = wr_err_q;
  assign lat_d     = lat_d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Self-checking bench for latch_wr_ctrl: timeline reference model, completion
// scoreboard, directed literal writes, mid-sequence reset and random traffic.
module tb_latch_wr_ctrl;
  import latch_wr_pkg::*;

  localparam int DW = 8;
  localparam int NW = 3;
  localparam int OC = 3;
  localparam int AW = 2;
`ifdef LATCH_WR_PARITY_EN
  localparam int LW = DW + 1;
`else
  localparam int LW = DW;
`endif

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready;
  logic [LW-1:0] lat_d;
  logic [NW-1:0] lat_gn;
  logic          busy;
  logic          wr_done;
  logic          wr_err;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one entry per accepted write, 1 = expect wr_done, 0 = wr_err.
  logic [0:0] exp_q[$];

  // Model: cycles elapsed since acceptance (0 = idle), plus captured request.
  int            m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_d = '0;

  latch_wr_ctrl #(
    .DW          (DW),
    .NWORDS      (NW),
    .OPEN_CYCLES (OC)
  ) dut (
    .CK        (CK),
    .RN        (RN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .lat_d     (lat_d),
    .lat_gn    (lat_gn),
    .busy      (busy),
    .wr_done   (wr_done),
    .wr_err    (wr_err),
    .dbg_state (dbg_state)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] model_lat_d(input logic [DW-1:0] d);
`ifdef LATCH_WR_PARITY_EN
    return {1'($countones(d) % 2), d};
`else
    return d;
`endif
  endfunction

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_t = 0;
      m_d = '0;
      exp_q.delete();
    end else if (m_t != 0) begin
      m_t = (m_t == OC + 2) ? 0 : m_t + 1;
    end else if (req_valid) begin
      m_t    = 1;
      m_addr = req_addr;
      m_d    = model_lat_d(req_data);
      exp_q.push_back(1'(int'(req_addr) < NW));
    end
  end

  always @(negedge CK) begin
    logic [NW-1:0] e_gn;
    logic          ok;
    logic [0:0]    ent;
    ok   = int'(m_addr) < NW;
    e_gn = '1;
    if (m_t >= 2 && m_t <= OC + 1 && ok) e_gn[m_addr] = 1'b0;
    check("m_ready", 64'(req_ready), 64'(m_t == 0));
    check("m_busy", 64'(busy), 64'(m_t != 0));
    check("m_gn", 64'(lat_gn), 64'(e_gn));
    check("m_lat_d", 64'(lat_d), 64'(m_d));
    check("m_done", 64'(wr_done), 64'(m_t == OC + 2 && ok));
    check("m_err", 64'(wr_err), 64'(m_t == OC + 2 && !ok));
    check("gn_at_most_one_low", 64'($countones(~lat_gn) <= 1), 64'(1));
    if (wr_done || wr_err) begin
      check("sb_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        check("sb_kind", 64'({wr_done, wr_err}), 64'({ent[0], ~ent[0]}));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CK);
    while (!req_ready && n < 60) begin
      @(negedge CK);
      n++;
    end
    check("idle_timeout", 64'(req_ready), 64'(1));
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CK);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check("accept_timeout", 64'(acc), 64'(1));
    @(posedge CK);
    #1;
    req_valid = 1'b0;
    req_addr  = 2'($urandom);
    req_data  = 8'($urandom);
  endtask

  // Directed write from idle with literal expectations for every cycle.
  task automatic lit_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic par,
                           input logic [NW-1:0] gn_open, input logic exp_done);
    logic [LW-1:0] e_ld;
`ifdef LATCH_WR_PARITY_EN
    e_ld = {par, d};
`else
    e_ld = d;
    if (par) e_ld = d;
`endif
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge CK);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= OC + 2; k++) begin
      @(negedge CK);
      check("lit_lat_d", 64'(lat_d), 64'(e_ld));
      check("lit_gn", 64'(lat_gn), (k >= 2 && k <= OC + 1) ? 64'(gn_open) : 64'(3'b111));
      check("lit_ready_low", 64'(req_ready), 64'(0));
      check("lit_done", 64'(wr_done), 64'(k == OC + 2 && exp_done));
      check("lit_err", 64'(wr_err), 64'(k == OC + 2 && !exp_done));
    end
    @(negedge CK);
    check("lit_next_ready", 64'(req_ready), 64'(1));
  endtask

  task automatic mid_reset();
    logic seen;
    wait_idle();
    send(2'd1, 8'hC3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CK);
      if (lat_gn != 3'b111) begin
        seen = 1'b1;
        break;
      end
    end
    check("mr_gate_opened", 64'(seen), 64'(1));
    #1 RN = 1'b0;
    #1;
    check("mr_async_gn", 64'(lat_gn), 64'(3'b111));
    check("mr_async_busy", 64'(busy), 64'(0));
    check("mr_async_ready", 64'(req_ready), 64'(1));
    #1 RN = 1'b1;
    for (int i = 0; i < OC + 3; i++) begin
      @(negedge CK);
      check("mr_no_done", 64'(wr_done), 64'(0));
      check("mr_idle_state", 64'(dbg_state), 64'(IDLE));
    end
  endtask

  initial begin
    RN        = 1'b0;
    req_valid = 1'b1;
    req_addr  = 2'd1;
    req_data  = 8'h5A;
    repeat (3) @(negedge CK);
    check("rst_gn", 64'(lat_gn), 64'(3'b111));
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_lat_d", 64'(lat_d), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(wr_done), 64'(0));
    check("rst_err", 64'(wr_err), 64'(0));
    #1 RN = 1'b1;
    @(posedge CK);
    #1 req_valid = 1'b0;
    @(negedge CK);
    check("rst_first_accept", 64'(busy), 64'(1));
    check("rst_first_lat_d", 64'(lat_d[DW-1:0]), 64'(8'h5A));

    wait_idle();
    lit_write(2'd2, 8'hA5, 1'b0, 3'b011, 1'b1);
    wait_idle();
    lit_write(2'd0, 8'h3C, 1'b0, 3'b110, 1'b1);
    wait_idle();
    lit_write(2'd3, 8'h07, 1'b1, 3'b111, 1'b0);
    wait_idle();
    lit_write(2'd1, 8'h03, 1'b0, 3'b101, 1'b1);
    wait_idle();
    lit_write(2'd1, 8'hFE, 1'b1, 3'b101, 1'b1);

    mid_reset();

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CK);
      send(2'($urandom_range(0, 3)), 8'($urandom));
    end

    wait_idle();
    repeat (2) @(negedge CK);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
